// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the CPU load/store unit and a DMA/fill engine.
// Optional conflict counter: define ARB_STATS_EN to build stat_conflicts.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned MAX_BURST    = 8,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_lock,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       stat_conflicts
);

   localparam int unsigned WAIT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               locked_q, locked_d;
   logic               dma_win, burst_full;

   assign burst_full = (burst_cnt_q == BURST_W'(MAX_BURST));
   assign dma_win    = (locked_q && !burst_full) || (wait_cnt_q == WAIT_W'(STARVE_LIMIT));

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!reset) begin
         if (dma_req && (!cpu_req || dma_win)) begin
            dma_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

   // Idle cycles park the CPU request on the memory bus with the strobe off.
   assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
   assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
   assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!dma_req || dma_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_W'(STARVE_LIMIT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end

      locked_d = locked_q;
      if (!dma_req || burst_full) begin
         locked_d = 1'b0;
      end else if (dma_gnt) begin
         locked_d = dma_lock;
      end

      // Burst length is only bounded while the CPU is actually waiting.
      burst_cnt_d = burst_cnt_q;
      if (!locked_d) begin
         burst_cnt_d = '0;
      end else if (dma_gnt && cpu_req && locked_q) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q  <= '0;
         burst_cnt_q <= '0;
         locked_q    <= 1'b0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         locked_q    <= locked_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [31:0] stat_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_q <= '0;
      end else if (cpu_req && dma_req) begin
         stat_q <= stat_q + 32'd1;
      end
   end

   assign stat_conflicts = stat_q;
`else
   assign stat_conflicts = 32'h0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory port between the processor load/store unit (CPU port) and a DMA/fill engine (DMA port). Grant decisions are combinational within the cycle, so an uncontested CPU access completes with zero added latency. Fairness and burst state are held in registers. The block sits between processor, dmemory and the DMA engine. When the CPU loses arbitration, the block drives cpu_stall, which holds the PC and suppresses register writeback.

Parameters:
STARVE_LIMIT, 4, consecutive cycles the DMA may wait while the CPU holds the port before the DMA is forced a grant
MAX_BURST, 8, maximum consecutive locked DMA grants while the CPU is requesting
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU requests a memory access this cycle
cpu_we  in  1  CPU access is a write
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data
cpu_gnt  out  1  CPU access is performed this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
dma_req  in  1  DMA requests an access
dma_lock  in  1  DMA requests burst lock; sampled only when dma_gnt=1
dma_we  in  1  DMA access is a write
dma_addr  in  ADDR_W  DMA byte address
dma_wdata  in  DATA_W  DMA write data
dma_rdata  out  DATA_W  DMA read data
dma_gnt  out  1  DMA access is performed this cycle
mem_we  out  1  write strobe to dmemory; write commits on the next rising clk edge
mem_addr  out  ADDR_W  address to dmemory
mem_wdata  out  DATA_W  write data to dmemory
mem_rdata  in  DATA_W  combinational read data from dmemory
stat_conflicts  out  32  count of cycles with both requests asserted (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. While reset is asserted, all registers clear: wait_cnt=0, burst_cnt=0, locked=0, stat_conflicts=0. Gnt outputs are forced to 0 while reset=1.
- Grant, combinational, at most one grant per cycle:
  - Neither requests: no grant; mem_we=0; mem_addr/mem_wdata hold the CPU values.
  - Exactly one requests: that requester is granted.
  - Both request: the DMA is granted if (locked && burst_cnt<MAX_BURST) or wait_cnt==STARVE_LIMIT; otherwise the CPU is granted.
- Mux: mem_we/addr/wdata come from the granted port. mem_we=0 when there is no grant.
- Read data: mem_rdata is routed to both cpu_rdata and dma_rdata. The read data is valid only for the port whose gnt is 1.
- wait_cnt:
  - Increments on clk when dma_req && !dma_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 on any cycle with dma_gnt=1 or dma_req=0.
- locked:
  - Set on clk when dma_gnt && dma_lock.
  - Cleared when dma_req=0, or when a DMA-granted cycle has dma_lock=0.
  - Cleared when burst_cnt reaches MAX_BURST.
- burst_cnt:
  - Increments on each DMA grant while cpu_req=1 and locked=1.
  - Clears when locked clears.
  - With cpu_req=0, a locked DMA runs unbounded and burst_cnt does not advance.
- When burst_cnt==MAX_BURST and the CPU is requesting, the CPU wins the next cycle. locked and burst_cnt clear on that edge.
- Starvation override lasts exactly one cycle. The DMA grant clears wait_cnt, so the CPU regains the port on the following cycle unless lock applies.
- Reset mid-burst: locked and counters clear immediately. After reset deasserts, arbitration restarts with CPU priority.
- No address checking or alignment masking; addresses pass through unchanged.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: stat_conflicts increments by 1 on every clk edge where cpu_req && dma_req. It wraps modulo 2^32 and clears on reset.
- Undefined: the counter register is not built and stat_conflicts is tied to 32'h0.
- Arbitration behaviour is identical either way.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr 0x0, wdata 0xFEFEFEFE for 1 cycle -> cpu_gnt=1, cpu_stall=0, mem_we=1; a read of 0x0 the next cycle returns 0xFEFEFEFE.
- Starvation: cpu_req and dma_req held high, dma_lock=0, STARVE_LIMIT=4 -> grants follow the repeating pattern CPU×4, DMA×1; cpu_stall=1 on each DMA cycle.
- Burst lock: DMA granted alone with dma_lock=1, then the CPU requests continuously, MAX_BURST=8 -> 8 more consecutive DMA grants, then cpu_gnt=1; locked=0 afterwards.
- DMA fill: DMA alone writes 0xFEFEFEFE to addresses 0..60 step 4 (16 writes), with cpu_req=0 -> 16 consecutive dma_gnt cycles; all 64 memory bytes read back as 0xFE.
- Reset mid-burst: assert reset asynchronously during a locked DMA burst -> gnts drop immediately with no clock edge needed; after release with both requesting, the CPU is granted first.
- ARB_STATS_EN defined, 10 cycles with both requests asserted -> stat_conflicts=10; with the macro undefined -> stat_conflicts=0.
